// File: rtl/instr_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the RV32I encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words, flags unrepresentable immediates,
// and streams them through a 2-entry FIFO with sequential byte addresses.
module instr_encoder #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] cfg_base,
  instr_encoder_if.slave    bus,
  output logic              err_sticky,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0]       enc_word;
  logic              enc_err;
  logic signed [31:0] imm_s;

  logic [1:0][31:0]  fifo_instr_q, fifo_instr_d;
  logic [1:0]        fifo_err_q, fifo_err_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sticky_q, sticky_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              push, pop;

  assign imm_s = bus.in_imm;

  always_comb begin
    enc_word = 32'h0000_0013;
    enc_err  = 1'b1;
    case (bus.in_fmt)
      FMT_R: begin
        enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        enc_err  = 1'b0;
      end
      FMT_I: begin
        enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_S: begin
        enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_imm[4:0], bus.in_opcode};
        enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_B: begin
        enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
        enc_err  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.in_imm[0];
      end
      FMT_U: begin
        enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
        enc_err  = (bus.in_imm[11:0] != 12'h000);
      end
      FMT_J: begin
        enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                    bus.in_rd, bus.in_opcode};
        enc_err  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || bus.in_imm[0];
      end
      default: begin
        enc_word = 32'h0000_0013;
        enc_err  = 1'b1;
      end
    endcase
  end

  // cfg_load blocks both sides so the flush cycle neither accepts nor retires a word
  assign bus.in_ready  = !cfg_load && (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = fifo_instr_q[rd_ptr_q];
  assign bus.out_err   = fifo_err_q[rd_ptr_q];
  assign bus.out_addr  = addr_q;
  assign err_sticky    = sticky_q;
  assign word_count    = wcnt_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready && !cfg_load;

  always_comb begin
    fifo_instr_d = fifo_instr_q;
    fifo_err_d   = fifo_err_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    addr_d       = addr_q;
    sticky_d     = sticky_q;
    wcnt_d       = wcnt_q;
    if (cfg_load) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
      addr_d   = cfg_base & ~ADDR_W'(3);
      sticky_d = 1'b0;
      wcnt_d   = '0;
    end else begin
      if (push) begin
        fifo_instr_d[wr_ptr_q] = enc_word;
        fifo_err_d[wr_ptr_q]   = enc_err;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        addr_d   = addr_q + ADDR_W'(4);
        sticky_d = sticky_q | fifo_err_q[rd_ptr_q];
        if (wcnt_q != '1) wcnt_d = wcnt_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_instr_q <= '0;
      fifo_err_q   <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      addr_q       <= '0;
      sticky_q     <= 1'b0;
      wcnt_q       <= '0;
    end else begin
      fifo_instr_q <= fifo_instr_d;
      fifo_err_q   <= fifo_err_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      sticky_q     <= sticky_d;
      wcnt_q       <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings/flow cases plus randomized traffic
// against an arithmetic encoding model and a queue-based FIFO/address model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [31:0] cfg_base;
  logic        err_sticky;
  logic [15:0] word_count;

  logic        cfg_load4;
  logic [3:0]  cfg_base4;
  logic        err_sticky4;
  logic [15:0] word_count4;

  int checks = 0;
  int fails  = 0;

  instr_encoder_if #(.ADDR_W(32)) bus ();
  instr_encoder_if #(.ADDR_W(4))  bus4 ();

  instr_encoder #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_base(cfg_base),
    .bus(bus), .err_sticky(err_sticky), .word_count(word_count)
  );

  instr_encoder #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load4), .cfg_base(cfg_base4),
    .bus(bus4), .err_sticky(err_sticky4), .word_count(word_count4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned fld(input longint unsigned x, input int lo, input int n);
    return (x >> lo) % (64'd1 << n);
  endfunction

  // Reference encoder: places each field by shifting its numeric value into position.
  function automatic void ref_encode(input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
      output logic [31:0] w, output logic e);
    longint unsigned u, acc;
    int v;
    u = imm;
    v = imm;
    acc = op;
    e = 1'b0;
    case (fmt)
      3'd0: acc += (longint'(rd) << 7) + (longint'(f3) << 12) + (longint'(rs1) << 15)
                 + (longint'(rs2) << 20) + (longint'(f7) << 25);
      3'd1: begin
        acc += (longint'(rd) << 7) + (longint'(f3) << 12) + (longint'(rs1) << 15)
             + (fld(u, 0, 12) << 20);
        e = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        acc += (fld(u, 0, 5) << 7) + (longint'(f3) << 12) + (longint'(rs1) << 15)
             + (longint'(rs2) << 20) + (fld(u, 5, 7) << 25);
        e = (v < -2048) || (v > 2047);
      end
      3'd3: begin
        acc += (fld(u, 11, 1) << 7) + (fld(u, 1, 4) << 8) + (longint'(f3) << 12)
             + (longint'(rs1) << 15) + (longint'(rs2) << 20) + (fld(u, 5, 6) << 25)
             + (fld(u, 12, 1) << 31);
        e = (v < -4096) || (v > 4094) || (u % 2 != 0);
      end
      3'd4: begin
        acc += (longint'(rd) << 7) + (u - u % 4096);
        e = (u % 4096) != 0;
      end
      3'd5: begin
        acc += (longint'(rd) << 7) + (fld(u, 12, 8) << 12) + (fld(u, 11, 1) << 20)
             + (fld(u, 1, 10) << 21) + (fld(u, 20, 1) << 31);
        e = (v < -(1 << 20)) || (v > (1 << 20) - 2) || (u % 2 != 0);
      end
      default: begin
        acc = 64'h13;
        e = 1'b1;
      end
    endcase
    w = acc[31:0];
  endfunction

  // Behavioural flow model for the 32-bit instance
  logic [32:0] mq[$];
  logic [31:0] m_addr;
  int          m_cnt;
  logic        m_sticky;

  task automatic sb();
    logic [31:0] w;
    logic        e;
    logic [32:0] head;
    bit          can_push;
    if (rst) begin
      mq.delete();
      m_addr = '0;
      m_cnt = 0;
      m_sticky = 1'b0;
      return;
    end
    check_eq("sb_out_valid", bus.out_valid, mq.size() != 0);
    check_eq("sb_in_ready", bus.in_ready, (mq.size() < 2) && !cfg_load);
    check_eq("sb_out_addr", bus.out_addr, m_addr);
    check_eq("sb_word_count", word_count, m_cnt);
    check_eq("sb_err_sticky", err_sticky, m_sticky);
    if (cfg_load) begin
      mq.delete();
      m_addr = {cfg_base[31:2], 2'b00};
      m_cnt = 0;
      m_sticky = 1'b0;
      return;
    end
    can_push = (mq.size() < 2) && bus.in_valid;
    if (mq.size() != 0 && bus.out_ready) begin
      head = mq.pop_front();
      check_eq("sb_out_instr", bus.out_instr, head[31:0]);
      check_eq("sb_out_err", bus.out_err, head[32]);
      m_addr += 4;
      if (m_cnt < 65535) m_cnt++;
      m_sticky |= head[32];
    end
    if (can_push) begin
      ref_encode(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                 bus.in_funct3, bus.in_funct7, bus.in_imm, w, e);
      mq.push_back({e, w});
    end
  endtask

  task automatic settle();
    @(negedge clk);
    sb();
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    bus.in_fmt = fmt; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1;
    bus.in_rs2 = rs2; bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    bit acc = 0;
    set_fields(fmt, op, rd, rs1, rs2, f3, f7, imm);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      settle();
      acc = bus.in_ready;
      edge_();
    end
    bus.in_valid = 1'b0;
    if (!acc) check_eq("send_timeout", 0, 1);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] ew, input logic ee,
      input logic [31:0] ea);
    for (int i = 0; i < 20; i++) begin
      settle();
      if (bus.out_valid) begin
        check_eq({tag, "_instr"}, bus.out_instr, ew);
        check_eq({tag, "_err"}, bus.out_err, ee);
        check_eq({tag, "_addr"}, bus.out_addr, ea);
        edge_();
        return;
      end
      edge_();
    end
    check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_cfg(input logic [31:0] base);
    cfg_base = base;
    cfg_load = 1'b1;
    settle();
    check_eq("cfg_in_ready", bus.in_ready, 0);
    edge_();
    cfg_load = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm();
    int v;
    case ($urandom_range(0, 4))
      0: v = int'($urandom);
      1: v = int'($urandom_range(0, 8191)) - 4096;
      2: v = ($urandom_range(0, 1) != 0 ? 2047 : -2048) + int'($urandom_range(0, 2)) - 1;
      3: v = ($urandom_range(0, 1) != 0 ? (1 << 20) : -(1 << 20)) + int'($urandom_range(0, 4)) - 2;
      default: v = int'($urandom & 32'hFFFF_F000) + ($urandom_range(0, 3) == 0 ? 1 : 0);
    endcase
    return v;
  endfunction

  initial begin
    int seen4;
    logic [3:0] exp4 [4];
    rst = 1'b1; cfg_load = 1'b0; cfg_base = '0;
    cfg_load4 = 1'b0; cfg_base4 = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_fields(3'd0, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus4.in_fmt = 3'd0; bus4.in_opcode = 7'h33; bus4.in_rd = 5'd1; bus4.in_rs1 = 5'd2;
    bus4.in_rs2 = 5'd3; bus4.in_funct3 = 3'd0; bus4.in_funct7 = 7'd0; bus4.in_imm = 32'd0;
    repeat (3) begin settle(); edge_(); end
    rst = 1'b0;

    settle();
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_instr", bus.out_instr, 0);
    check_eq("rst_out_err", bus.out_err, 0);
    check_eq("rst_out_addr", bus.out_addr, 0);
    check_eq("rst_err_sticky", err_sticky, 0);
    check_eq("rst_word_count", word_count, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    edge_();

    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    expect_word("r_add", 32'h002081B3, 1'b0, 32'd0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    expect_word("i_neg1", 32'hFFF00093, 1'b0, 32'd4);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    expect_word("i_2048", 32'h80000093, 1'b1, 32'd8);
    settle();
    check_eq("sticky_set", err_sticky, 1);
    edge_();
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    expect_word("b_m4", 32'hFE000EE3, 1'b0, 32'd12);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    expect_word("j_2048", 32'h001000EF, 1'b0, 32'd16);
    send(3'd6, 7'h33, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'd5);
    expect_word("fmt6", 32'h00000013, 1'b1, 32'd20);

    // Backpressure: two accepts fill the FIFO, third waits for a slot
    pulse_cfg(32'd0);
    bus.out_ready = 1'b0;
    send(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0);
    send(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'd0, 32'd0);
    set_fields(3'd0, 7'h33, 5'd10, 5'd11, 5'd12, 3'd0, 7'h20, 32'd0);
    bus.in_valid = 1'b1;
    settle();
    check_eq("full_in_ready", bus.in_ready, 0);
    edge_();
    bus.out_ready = 1'b1;
    expect_word("bp_a", 32'h00628233, 1'b0, 32'd0);
    expect_word("bp_b", 32'h009403B3, 1'b0, 32'd4);
    bus.in_valid = 1'b0;
    expect_word("bp_c", 32'h40C58533, 1'b0, 32'd8);
    settle();
    check_eq("bp_word_count", word_count, 3);
    edge_();

    // Flush with queued words and a set sticky flag
    send(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5000);
    expect_word("i_5000", 32'h38800293, 1'b1, 32'd12);
    bus.out_ready = 1'b0;
    send(3'd0, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    send(3'd0, 7'h33, 5'd2, 5'd2, 5'd2, 3'd0, 7'd0, 32'd0);
    pulse_cfg(32'h0000_0103);
    settle();
    check_eq("flush_out_valid", bus.out_valid, 0);
    check_eq("flush_out_addr", bus.out_addr, 32'h100);
    check_eq("flush_sticky", err_sticky, 0);
    check_eq("flush_word_count", word_count, 0);
    edge_();
    bus.out_ready = 1'b1;
    send(3'd4, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    expect_word("u_lui", 32'h123454B7, 1'b0, 32'h100);

    for (int i = 0; i < 1500; i++) begin
      set_fields(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      cfg_load      = ($urandom_range(0, 59) == 0);
      cfg_base      = $urandom;
      settle();
      edge_();
    end
    cfg_load = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (4) begin settle(); edge_(); end

    // Narrow address counter: masked base 0x9 -> 0x8, then wraps past 0xC
    exp4[0] = 4'h8; exp4[1] = 4'hC; exp4[2] = 4'h0; exp4[3] = 4'h4;
    seen4 = 0;
    bus4.out_ready = 1'b1;
    cfg_base4 = 4'h9;
    cfg_load4 = 1'b1;
    edge_();
    cfg_load4 = 1'b0;
    bus4.in_valid = 1'b1;
    for (int i = 0; i < 20 && seen4 < 4; i++) begin
      @(negedge clk);
      if (bus4.out_valid) begin
        check_eq("w4_addr", bus4.out_addr, exp4[seen4]);
        check_eq("w4_instr", bus4.out_instr, 32'h003100B3);
        seen4++;
      end
      edge_();
    end
    bus4.in_valid = 1'b0;
    check_eq("w4_seen", seen4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
